// File: rtl/instr_seq_if.sv
// Instruction sequencer bus: run control, fetch port,
// decoded register fields, phase strobes and status.
interface instr_seq_if;
  logic        start;
  logic        stop;
  logic [31:0] Inst_Code;
  logic [31:0] IM_Addr;
  logic [4:0]  R_Addr_A;
  logic [4:0]  R_Addr_B;
  logic [4:0]  W_Addr;
  logic [3:0]  ALU_OP;
  logic        Reg_Write;
  logic        clk_RR;
  logic        clk_F;
  logic        clk_WB;
  logic        busy;
  logic        halted;
  logic        ill;
  logic [31:0] retired;

  modport master (
    input  start,
    input  stop,
    input  Inst_Code,
    output IM_Addr,
    output R_Addr_A,
    output R_Addr_B,
    output W_Addr,
    output ALU_OP,
    output Reg_Write,
    output clk_RR,
    output clk_F,
    output clk_WB,
    output busy,
    output halted,
    output ill,
    output retired
  );

  modport slave (
    output start,
    output stop,
    output Inst_Code,
    input  IM_Addr,
    input  R_Addr_A,
    input  R_Addr_B,
    input  W_Addr,
    input  ALU_OP,
    input  Reg_Write,
    input  clk_RR,
    input  clk_F,
    input  clk_WB,
    input  busy,
    input  halted,
    input  ill,
    input  retired
  );
endinterface

// File: rtl/instr_seq.sv
// Multi-cycle R-type instruction sequencer:
// IF -> ID -> RR -> EX -> WB with one-cycle phase strobes.
module instr_seq #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [6:0]  OPC_R    = 7'b0110011
) (
  input logic         clk,
  input logic         rst,
  instr_seq_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_IF,
    S_ID,
    S_RR,
    S_EX,
    S_WB,
    S_HALT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] ret_q, ret_d;
  logic        ill_q, ill_d;
  logic        rr_q, f_q, wb_q;
  logic        we_q, we_d;
  logic        busy_q, halt_q;
  logic        op_legal;
  logic        rd_nz;

  assign op_legal = (ir_q[6:0] == OPC_R);
  assign rd_nz    = (ir_q[11:7] != 5'd0);

  // Next state, PC, IR, retire count and sticky illegal flag
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    ret_d   = ret_q;
    ill_d   = ill_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_IF;
      end
      S_IF: begin
        ir_d    = bus.Inst_Code;
        state_d = S_ID;
      end
      S_ID: begin
        if (ir_q == 32'h0) begin
          state_d = S_HALT;
        end else begin
          state_d = S_RR;
          if (!op_legal) ill_d = 1'b1;
        end
      end
      S_RR: state_d = S_EX;
      S_EX: state_d = S_WB;
      S_WB: begin
        pc_d    = pc_q + 32'd4;
        ret_d   = ret_q + 32'd1;
        state_d = bus.stop ? S_IDLE : S_IF;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Write enable is decided while IR is already stable
  assign we_d = (state_d == S_WB) && op_legal && rd_nz;

  // State register plus every output derived from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= PC_RESET;
      ir_q    <= 32'h0;
      ret_q   <= 32'h0;
      ill_q   <= 1'b0;
      rr_q    <= 1'b0;
      f_q     <= 1'b0;
      wb_q    <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ret_q   <= ret_d;
      ill_q   <= ill_d;
      rr_q    <= (state_d == S_RR);
      f_q     <= (state_d == S_EX);
      wb_q    <= (state_d == S_WB);
      we_q    <= we_d;
      busy_q  <= !(state_d inside {S_IDLE, S_HALT});
      halt_q  <= (state_d == S_HALT);
    end
  end

  assign bus.IM_Addr   = pc_q;
  assign bus.R_Addr_A  = ir_q[19:15];
  assign bus.R_Addr_B  = ir_q[24:20];
  assign bus.W_Addr    = ir_q[11:7];
  assign bus.ALU_OP    = {ir_q[30], ir_q[14:12]};
  assign bus.Reg_Write = we_q;
  assign bus.clk_RR    = rr_q;
  assign bus.clk_F     = f_q;
  assign bus.clk_WB    = wb_q;
  assign bus.busy      = busy_q;
  assign bus.halted    = halt_q;
  assign bus.ill       = ill_q;
  assign bus.retired   = ret_q;

endmodule
